lsu_mem_bridge: RTL and testbench
=================================

// Module: lsu_mem_bridge
// PURPOSE
//  Sits directly downstream of the LSU: accepts one lsu_memory_* request, runs it on a 64-bit SRAM-style req/gnt/rvalid data bus, returns one memory_lsu_valid pulse.
//  Builds byte strobes, shifts write data into lane position, right-justifies read data (zero-filled; LSU does sign extension).
//  Splits accesses that cross an 8-byte boundary into two bus beats. Guards every beat with a response timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  1023  max cycles waiting for bus_gnt or bus_rvalid per beat before aborting with error
// PORTS
//  core_clk          in   1   single clock, all logic on posedge
//  core_rst_n        in   1   reset, asynchronous assert, active-low
//  lsu_memory_valid  in   1   one-cycle request pulse; addr/data/dir/width sampled this cycle only
//  lsu_memory_addr   in   64  byte address, any alignment
//  lsu_memory_data   in   64  store data, right-justified
//  lsu_memory_dir    in   1   0 = read, 1 = write
//  lsu_memory_width  in   4   bytes: 1,2,4,8 legal
//  memory_lsu_valid  out  1   one-cycle completion pulse
//  memory_lsu_data   out  64  load data right-justified, bytes above width zero; held until next completion
//  memory_lsu_err    out  1   valid with memory_lsu_valid: illegal width or timeout
//  bus_req           out  1   beat request, held until bus_gnt
//  bus_we            out  1   beat is a write
//  bus_addr          out  64  8-byte aligned beat address
//  bus_wdata         out  64  lane-positioned write data
//  bus_wstrb         out  8   byte enables (writes); 0 on reads
//  bus_gnt           in   1   request accepted this cycle
//  bus_rvalid        in   1   beat response (read data or write ack); >=1 cycle after gnt
//  bus_rdata         in   64  read beat data
// BEHAVIOUR
//  Reset (async, core_rst_n=0): state IDLE; memory_lsu_valid=0, memory_lsu_err=0, memory_lsu_data=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0; timeout counter 0. Reset mid-transaction abandons it silently; no completion pulse follows.
//  FSM: IDLE -> REQ0 -> RSP0 -> [REQ1 -> RSP1] -> DONE -> IDLE.
//   IDLE: on lsu_memory_valid latch addr/data/dir/width; off=addr[2:0]; split=(off+width>8). Illegal width -> DONE with err=1, no bus activity.
//   REQn: bus_req=1 with beat fields; on bus_gnt -> RSPn (bus_req low the next cycle).
//   RSP0: on bus_rvalid capture rdata; -> REQ1 if split else DONE. RSP1: on bus_rvalid -> DONE.
//   DONE: memory_lsu_valid=1 for exactly one cycle, data/err registered; -> IDLE.
//  Beat 0: bus_addr={addr[63:3],3'b0}; full strobe s16=((1<<width)-1)<<off (16 bits); wdata16=data<<(8*off) (128 bits); wstrb=s16[7:0], wdata=wdata16[63:0].
//  Beat 1: bus_addr=beat0 addr+8 (64-bit wrap, no carry-out); wstrb=s16[15:8], wdata=wdata16[127:64].
//  Read data: r = (rdata0>>(8*off)) | (split ? rdata1<<(8*(8-off)) : 0), then bytes >= width zeroed.
//  Latency (gnt same cycle as req, rvalid next cycle): aligned = request pulse at T, memory_lsu_valid at T+3; split = T+5; illegal width = T+1.
//  Timeout: counter clears on entering each REQn/RSPn; reaching TIMEOUT_CYCLES -> DONE with err=1, data=0, bus_req dropped. A late rvalid for an aborted beat is ignored while IDLE.
//  lsu_memory_valid while not IDLE is ignored (LSU holds off until completion). bus_rvalid outside RSPn is ignored.
//  Completion pulse and a new request pulse in the same cycle cannot occur: DONE always precedes IDLE.
// STRUCTURE
//  include/defines.v: FSM state encodings, BUS_DATA_W=64, BUS_STRB_W=8, legal width codes.
//  One combinational sub-module lsu_align: (off, width, dir, wdata, rdata0, rdata1, split) -> s16, wdata16, right-justified read result. The FSM, counter and output registers stay in lsu_mem_bridge.
// TESTING
//  LD addr 0x80000010, bus rdata 0x1122334455667788, gnt+rvalid immediate -> valid at T+3, data 0x1122334455667788, err=0.
//  LBU addr 0x80000013, rdata 0x1122334455667788 -> one beat, data 0x0000000000000055.
//  SW addr 0x80000006, data 0xAABBCCDD -> beat0 addr ..00 wstrb 0xC0 wdata[63:48]=0xCCDD; beat1 addr ..08 wstrb 0x03 wdata[15:0]=0xAABB; valid at T+5.
//  LW addr 0x8000000C with bus_gnt delayed 4 cycles and rvalid 2 cycles after gnt -> bus_req held 5 cycles, exactly one completion pulse.
//  Width=3 request -> valid at T+1, err=1, bus_req never asserted.
//  bus_rvalid never returns (TIMEOUT_CYCLES=15) -> err=1 after 15 wait cycles; core_rst_n pulled low during RSP0 -> all outputs 0 immediately, no completion pulse.

Source files
------------

// File: rtl/lsu_mem_bridge_pkg.sv
// Shared types and constants for the LSU-to-memory bridge.
// State encodings, bus geometry and legal access widths.
package lsu_mem_bridge_pkg;

    localparam int BUS_DATA_W = 64;
    localparam int BUS_STRB_W = 8;

    localparam logic [3:0] WIDTH_B = 4'd1;
    localparam logic [3:0] WIDTH_H = 4'd2;
    localparam logic [3:0] WIDTH_W = 4'd4;
    localparam logic [3:0] WIDTH_D = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ0 = 3'd1,
        ST_RSP0 = 3'd2,
        ST_REQ1 = 3'd3,
        ST_RSP1 = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
        logic        dir;
        logic [3:0]  width;
    } req_t;

    function automatic logic width_legal(input logic [3:0] width);
        return (width == WIDTH_B) || (width == WIDTH_H) ||
               (width == WIDTH_W) || (width == WIDTH_D);
    endfunction

endpackage

// File: rtl/lsu_mem_bridge_align.sv
// Lane alignment: byte strobes, write-data lane shift and read right-justify.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Consumer picks beat 0 from bits [7:0]/[63:0] and beat 1 from the upper halves.
module lsu_mem_bridge_align
    import lsu_mem_bridge_pkg::*;
(
    input  logic [2:0]              off,
    input  logic [3:0]              width,
    input  logic                    dir,
    input  logic [BUS_DATA_W-1:0]   wdata,
    input  logic [BUS_DATA_W-1:0]   rdata0,
    input  logic [BUS_DATA_W-1:0]   rdata1,
    input  logic                    split,
    output logic [15:0]             s16,
    output logic [127:0]            wdata16,
    output logic [BUS_DATA_W-1:0]   rdata
);

    logic [15:0]           width_mask;
    logic [5:0]            rsh;
    logic [6:0]            lsh;
    logic [BUS_DATA_W-1:0] rjust;

    always_comb begin
        width_mask = (16'd1 << width) - 16'd1;
        s16        = dir ? (width_mask << off) : 16'd0;
        wdata16    = {64'd0, wdata} << {off, 3'b000};

        // Second beat supplies the bytes that spilled past the 8-byte line.
        rsh   = {off, 3'b000};
        lsh   = 7'd64 - {1'b0, off, 3'b000};
        rjust = (rdata0 >> rsh) | (split ? (rdata1 << lsh) : 64'd0);

        rdata = '0;
        for (int b = 0; b < BUS_STRB_W; b++) begin
            rdata[8*b +: 8] = width_mask[b] ? rjust[8*b +: 8] : 8'h00;
        end
    end

endmodule

// File: rtl/lsu_mem_bridge.sv
// LSU request to 64-bit req/gnt/rvalid bus bridge, splitting line-crossing accesses.
// Latency: 3 cycles aligned, 5 split, 1 for illegal width (zero-wait bus).
// Backpressure: bus_req held until bus_gnt; each wait bounded by TIMEOUT_CYCLES.
module lsu_mem_bridge
    import lsu_mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
)
(
    input  logic                    core_clk,
    input  logic                    core_rst_n,
    input  logic                    lsu_memory_valid,
    input  logic [63:0]             lsu_memory_addr,
    input  logic [63:0]             lsu_memory_data,
    input  logic                    lsu_memory_dir,
    input  logic [3:0]              lsu_memory_width,
    output logic                    memory_lsu_valid,
    output logic [63:0]             memory_lsu_data,
    output logic                    memory_lsu_err,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [63:0]             bus_addr,
    output logic [BUS_DATA_W-1:0]   bus_wdata,
    output logic [BUS_STRB_W-1:0]   bus_wstrb,
    input  logic                    bus_gnt,
    input  logic                    bus_rvalid,
    input  logic [BUS_DATA_W-1:0]   bus_rdata
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    req_t                   req_q;
    logic                   split_q;
    logic [BUS_DATA_W-1:0]  rdata0_q;
    logic [CNT_W-1:0]       tmo_q;

    logic [15:0]            s16;
    logic [127:0]           wdata16;
    logic [BUS_DATA_W-1:0]  rd_res;
    logic [BUS_DATA_W-1:0]  rdata0_sel;
    logic [63:0]            beat0_addr;
    logic [4:0]             span;
    logic                   tmo_hit;
    logic                   in_wait;
    logic                   fin;
    logic                   fin_err;
    logic [63:0]            fin_data;
    logic                   cap_rd0;

    assign beat0_addr = {req_q.addr[63:3], 3'b000};
    assign span       = {2'b00, lsu_memory_addr[2:0]} + {1'b0, lsu_memory_width};
    assign tmo_hit    = (tmo_q == TMO_LAST);
    assign in_wait    = (state_q == ST_REQ0) || (state_q == ST_RSP0) ||
                        (state_q == ST_REQ1) || (state_q == ST_RSP1);
    // Single-beat completion reads straight off the bus in the capture cycle.
    assign rdata0_sel = (state_q == ST_RSP0) ? bus_rdata : rdata0_q;

    lsu_mem_bridge_align u_align (
        .off     (req_q.addr[2:0]),
        .width   (req_q.width),
        .dir     (req_q.dir),
        .wdata   (req_q.data),
        .rdata0  (rdata0_sel),
        .rdata1  (bus_rdata),
        .split   (split_q),
        .s16     (s16),
        .wdata16 (wdata16),
        .rdata   (rd_res)
    );

    always_comb begin
        state_d  = state_q;
        fin      = 1'b0;
        fin_err  = 1'b0;
        fin_data = '0;
        cap_rd0  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lsu_memory_valid) begin
                    if (width_legal(lsu_memory_width)) begin
                        state_d = ST_REQ0;
                    end else begin
                        state_d = ST_DONE;
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end
                end
            end
            ST_REQ0, ST_REQ1: begin
                if (bus_gnt) begin
                    state_d = (state_q == ST_REQ0) ? ST_RSP0 : ST_RSP1;
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            ST_RSP0, ST_RSP1: begin
                if (bus_rvalid) begin
                    if (state_q == ST_RSP0 && split_q) begin
                        state_d = ST_REQ1;
                        cap_rd0 = 1'b1;
                    end else begin
                        state_d  = ST_DONE;
                        fin      = 1'b1;
                        fin_data = req_q.dir ? 64'd0 : rd_res;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_wstrb = '0;
        if (state_q == ST_REQ0) begin
            bus_req   = 1'b1;
            bus_we    = req_q.dir;
            bus_addr  = beat0_addr;
            bus_wdata = req_q.dir ? wdata16[63:0] : 64'd0;
            bus_wstrb = s16[7:0];
        end else if (state_q == ST_REQ1) begin
            bus_req   = 1'b1;
            bus_we    = req_q.dir;
            bus_addr  = beat0_addr + 64'd8;
            bus_wdata = req_q.dir ? wdata16[127:64] : 64'd0;
            bus_wstrb = s16[15:8];
        end
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q          <= ST_IDLE;
            req_q            <= '0;
            split_q          <= 1'b0;
            rdata0_q         <= '0;
            tmo_q            <= '0;
            memory_lsu_valid <= 1'b0;
            memory_lsu_err   <= 1'b0;
            memory_lsu_data  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && lsu_memory_valid) begin
                req_q.addr  <= lsu_memory_addr;
                req_q.data  <= lsu_memory_data;
                req_q.dir   <= lsu_memory_dir;
                req_q.width <= lsu_memory_width;
                split_q     <= (span > 5'd8);
            end
            if (cap_rd0) begin
                rdata0_q <= bus_rdata;
            end
            // Every REQn/RSPn entry restarts the per-beat wait budget.
            if (state_d != state_q) begin
                tmo_q <= '0;
            end else if (in_wait) begin
                tmo_q <= tmo_q + 1'b1;
            end
            memory_lsu_valid <= fin;
            if (fin) begin
                memory_lsu_err  <= fin_err;
                memory_lsu_data <= fin_data;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Self-checking bench for lsu_mem_bridge: byte-level reference memory plus scoreboard.
module tb_lsu_mem_bridge;

    localparam int TMO = 15;

    logic        core_clk = 1'b0;
    logic        core_rst_n;
    logic        lsu_memory_valid;
    logic [63:0] lsu_memory_addr;
    logic [63:0] lsu_memory_data;
    logic        lsu_memory_dir;
    logic [3:0]  lsu_memory_width;
    logic        memory_lsu_valid;
    logic [63:0] memory_lsu_data;
    logic        memory_lsu_err;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [63:0] bus_rdata;

    lsu_mem_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .core_clk         (core_clk),
        .core_rst_n       (core_rst_n),
        .lsu_memory_valid (lsu_memory_valid),
        .lsu_memory_addr  (lsu_memory_addr),
        .lsu_memory_data  (lsu_memory_data),
        .lsu_memory_dir   (lsu_memory_dir),
        .lsu_memory_width (lsu_memory_width),
        .memory_lsu_valid (memory_lsu_valid),
        .memory_lsu_data  (memory_lsu_data),
        .memory_lsu_err   (memory_lsu_err),
        .bus_req          (bus_req),
        .bus_we           (bus_we),
        .bus_addr         (bus_addr),
        .bus_wdata        (bus_wdata),
        .bus_wstrb        (bus_wstrb),
        .bus_gnt          (bus_gnt),
        .bus_rvalid       (bus_rvalid),
        .bus_rdata        (bus_rdata)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        string       tag;
        logic [63:0] data;
        logic        err;
        bit          chk_data;
        int          lat;
        int          t0;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [7:0]  strb;
        logic [63:0] wdata;
    } beat_t;

    exp_t        sb[$];
    beat_t       beats[$];
    exp_t        mon_e;
    logic [63:0] mem     [16];
    logic [63:0] ref_mem [16];

    int n_chk = 0;
    int n_err = 0;
    int n_vld = 0;
    int cyc = 0;
    int req_cyc = 0;

    // bus responder controls
    int          gnt_dly = 0;
    int          rv_dly = 1;
    bit          no_rsp = 1'b0;
    bit          inject_rv = 1'b0;
    bit          pend_rsp = 1'b0;
    int          rv_cnt = 0;
    int          g_cnt = 0;
    logic [63:0] pend_data = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(posedge core_clk) cyc <= cyc + 1;

    always @(negedge core_clk) begin
        if (core_rst_n && memory_lsu_valid) begin
            n_vld++;
            if (sb.size() == 0) begin
                chk("unexpected_vld", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("%s_err", mon_e.tag), {63'd0, memory_lsu_err}, {63'd0, mon_e.err});
                if (mon_e.chk_data)
                    chk($sformatf("%s_data", mon_e.tag), memory_lsu_data, mon_e.data);
                chk($sformatf("%s_lat", mon_e.tag), 64'(cyc - mon_e.t0), 64'(mon_e.lat));
            end
        end
        if (bus_req) req_cyc++;
    end

    always @(negedge core_clk) begin
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        if (inject_rv) begin
            bus_rvalid = 1'b1;
            bus_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
            inject_rv  = 1'b0;
        end else if (pend_rsp) begin
            if (!no_rsp) begin
                if (rv_cnt <= 1) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = pend_data;
                    pend_rsp   = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end
        end else if (bus_req) begin
            if (g_cnt >= gnt_dly) begin
                bus_gnt = 1'b1;
                g_cnt   = 0;
                beats.push_back('{bus_addr, bus_we, bus_wstrb, bus_wdata});
                if (bus_we) begin
                    for (int b = 0; b < 8; b++)
                        if (bus_wstrb[b]) mem[bus_addr[6:3]][8*b +: 8] = bus_wdata[8*b +: 8];
                end
                pend_data = mem[bus_addr[6:3]];
                pend_rsp  = 1'b1;
                rv_cnt    = rv_dly;
            end else begin
                g_cnt++;
            end
        end
    end

    task automatic set_bus(input int gd, input int rd, input bit nr);
        gnt_dly  = gd;
        rv_dly   = rd;
        no_rsp   = nr;
        pend_rsp = 1'b0;
        g_cnt    = 0;
    endtask

    task automatic drive_req(input logic dir, input logic [63:0] addr,
                             input logic [63:0] data, input logic [3:0] width);
        lsu_memory_valid = 1'b1;
        lsu_memory_dir   = dir;
        lsu_memory_addr  = addr;
        lsu_memory_data  = data;
        lsu_memory_width = width;
        @(negedge core_clk);
        lsu_memory_valid = 1'b0;
        lsu_memory_data  = '0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge core_clk);
        chk("completion_wait", 64'(sb.size()), 64'd0);
        sb.delete();
        repeat (2) @(negedge core_clk);
    endtask

    // lat_ovr > 0 overrides the zero-wait latency; tmo expects an aborted read.
    task automatic issue(input string tag, input logic dir, input logic [63:0] addr,
                         input logic [63:0] data, input logic [3:0] width,
                         input int lat_ovr, input bit tmo);
        exp_t        e;
        logic [63:0] a;
        bit          legal;
        legal      = (width == 4'd1) || (width == 4'd2) || (width == 4'd4) || (width == 4'd8);
        e.tag      = tag;
        e.err      = !legal || tmo;
        e.data     = '0;
        e.chk_data = !dir || !legal;
        if (legal && !tmo) begin
            for (int i = 0; i < int'(width); i++) begin
                a = addr + 64'(i);
                if (dir) ref_mem[a[6:3]][int'(a[2:0])*8 +: 8] = data[8*i +: 8];
                else     e.data[8*i +: 8] = ref_mem[a[6:3]][int'(a[2:0])*8 +: 8];
            end
        end
        if (lat_ovr > 0)  e.lat = lat_ovr;
        else if (!legal)  e.lat = 1;
        else              e.lat = (int'(addr[2:0]) + int'(width) > 8) ? 5 : 3;
        e.t0 = cyc;
        sb.push_back(e);
        drive_req(dir, addr, data, width);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  w;
        logic [63:0] rnd;
        int          n0;
        core_rst_n       = 1'b0;
        lsu_memory_valid = 1'b0;
        lsu_memory_addr  = '0;
        lsu_memory_data  = '0;
        lsu_memory_dir   = 1'b0;
        lsu_memory_width = '0;
        bus_gnt          = 1'b0;
        bus_rvalid       = 1'b0;
        bus_rdata        = '0;
        for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
        mem[2] = 64'h1122_3344_5566_7788;
        for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];

        repeat (3) @(negedge core_clk);
        chk("rst_valid", {63'd0, memory_lsu_valid}, 64'd0);
        chk("rst_err",   {63'd0, memory_lsu_err},   64'd0);
        chk("rst_data",  memory_lsu_data, 64'd0);
        chk("rst_req",   {63'd0, bus_req}, 64'd0);
        chk("rst_addr",  bus_addr, 64'd0);
        chk("rst_wstrb", {56'd0, bus_wstrb}, 64'd0);
        core_rst_n = 1'b1;
        repeat (2) @(negedge core_clk);

        issue("ld_aligned", 1'b0, 64'h8000_0010, '0, 4'd8, 0, 1'b0);
        beats.delete();
        issue("lbu", 1'b0, 64'h8000_0013, '0, 4'd1, 0, 1'b0);
        chk("lbu_beats", 64'(beats.size()), 64'd1);

        beats.delete();
        issue("sw_split", 1'b1, 64'h8000_0006, 64'hAABB_CCDD, 4'd4, 0, 1'b0);
        chk("sw_beats", 64'(beats.size()), 64'd2);
        if (beats.size() == 2) begin
            chk("sw_b0_addr",  beats[0].addr, 64'h8000_0000);
            chk("sw_b0_we",    {63'd0, beats[0].we}, 64'd1);
            chk("sw_b0_strb",  {56'd0, beats[0].strb}, 64'hC0);
            chk("sw_b0_wdata", {48'd0, beats[0].wdata[63:48]}, 64'hCCDD);
            chk("sw_b1_addr",  beats[1].addr, 64'h8000_0008);
            chk("sw_b1_strb",  {56'd0, beats[1].strb}, 64'h03);
            chk("sw_b1_wdata", {48'd0, beats[1].wdata[15:0]}, 64'hAABB);
        end
        issue("lw_readback", 1'b0, 64'h8000_0006, '0, 4'd4, 0, 1'b0);
        issue("lh_split",    1'b0, 64'h8000_0007, '0, 4'd2, 0, 1'b0);
        issue("sd_split",    1'b1, 64'h8000_001D, 64'h0123_4567_89AB_CDEF, 4'd8, 0, 1'b0);
        issue("ld_split",    1'b0, 64'h8000_001D, '0, 4'd8, 0, 1'b0);

        beats.delete();
        issue("ld_wrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, '0, 4'd8, 0, 1'b0);
        chk("wrap_beats", 64'(beats.size()), 64'd2);
        if (beats.size() == 2) begin
            chk("wrap_b0_addr", beats[0].addr, 64'hFFFF_FFFF_FFFF_FFF8);
            chk("wrap_b1_addr", beats[1].addr, 64'h0);
        end

        set_bus(4, 2, 1'b0);
        req_cyc = 0;
        n0 = n_vld;
        issue("lw_slow", 1'b0, 64'h8000_000C, '0, 4'd4, 8, 1'b0);
        chk("slow_req_cycles", 64'(req_cyc), 64'd5);
        chk("slow_pulses", 64'(n_vld - n0), 64'd1);
        set_bus(0, 1, 1'b0);

        req_cyc = 0;
        issue("width3", 1'b0, 64'h8000_0010, '0, 4'd3, 0, 1'b0);
        issue("width0", 1'b1, 64'h8000_0010, 64'hFF, 4'd0, 0, 1'b0);
        chk("illegal_req_cycles", 64'(req_cyc), 64'd0);

        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 3))
                0:       w = 4'd1;
                1:       w = 4'd2;
                2:       w = 4'd4;
                default: w = 4'd8;
            endcase
            rnd = {$urandom, $urandom};
            issue($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)),
                  64'h8000_0000 + 64'($urandom_range(0, 63)), rnd, w, 0, 1'b0);
        end

        set_bus(0, 1, 1'b1);
        issue("timeout", 1'b0, 64'h8000_0020, '0, 4'd8, TMO + 2, 1'b1);
        n0 = n_vld;
        inject_rv = 1'b1;
        repeat (6) @(negedge core_clk);
        chk("late_rvalid_ignored", 64'(n_vld - n0), 64'd0);
        set_bus(0, 1, 1'b0);

        issue("ld_pre_rst", 1'b0, 64'h8000_0010, '0, 4'd8, 0, 1'b0);
        set_bus(0, 1, 1'b1);
        n0 = n_vld;
        drive_req(1'b0, 64'h8000_0010, '0, 4'd8);
        @(negedge core_clk);
        chk("rsp0_req_low", {63'd0, bus_req}, 64'd0);
        core_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, memory_lsu_valid}, 64'd0);
        chk("mid_rst_data",  memory_lsu_data, 64'd0);
        chk("mid_rst_err",   {63'd0, memory_lsu_err}, 64'd0);
        chk("mid_rst_req",   {63'd0, bus_req}, 64'd0);
        repeat (3) @(negedge core_clk);
        core_rst_n = 1'b1;
        set_bus(0, 1, 1'b0);
        repeat (20) @(negedge core_clk);
        chk("rst_no_pulse", 64'(n_vld - n0), 64'd0);
        issue("lbu_post_rst", 1'b0, 64'h8000_0011, '0, 4'd1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
